// File: rtl/i2c_apb_master.sv
// ---------------------------------------------------------------------------
// i2c_apb_master
//   Turns a single-outstanding command/response stream into APB transfers.
//   Each accepted command produces one SETUP cycle, one or more ACCESS
//   cycles, and exactly one response. An ACCESS phase that waits too long on
//   the slave is aborted and reported as an error.
//
// Parameters
//   TIMEOUT   : maximum number of ACCESS cycles before the transfer is
//               aborted (0 disables the abort)
//
// Ports
//   clk, rstn                     : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_write/cmd_addr/cmd_wdata  : command payload (1 = write)
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata/rsp_err             : read data (0 for writes, 32'hdeadbeef on
//                                   timeout) and timeout flag
//   apb_sel/apb_en/apb_write      : APB control
//   apb_addr/apb_wdata            : APB address and write data
//   apb_ready/apb_rdata           : APB slave completion and read data
//   busy                          : high whenever a transfer is in progress
// ---------------------------------------------------------------------------
module i2c_apb_master #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  input  logic        apb_ready,
  input  logic [31:0] apb_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hdeadbeef;
  // Counter value at which the last permitted ACCESS cycle is running.
  localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_apb_sel;
  logic        r_apb_en;
  logic        r_apb_write;
  logic [31:0] r_apb_addr;
  logic [31:0] r_apb_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [15:0] r_wait_cnt;

  logic        w_cmd_fire;
  logic        w_rsp_fire;
  logic        w_timeout;

  assign w_cmd_fire = cmd_valid & r_cmd_ready;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  // Only meaningful while in ACCESS with apb_ready low; apb_ready wins ties.
  assign w_timeout  = (TIMEOUT != 16'd0) && (r_wait_cnt == TO_LAST);

  // Single FSM; every output is a register updated alongside the state so
  // the outputs change cleanly on the clock edge and clear asynchronously
  // on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_apb_sel   <= 1'b0;
      r_apb_en    <= 1'b0;
      r_apb_write <= 1'b0;
      r_apb_addr  <= 32'h0;
      r_apb_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_wait_cnt  <= 16'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_state     <= ST_SETUP;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_apb_sel   <= 1'b1;
            r_apb_en    <= 1'b0;
            // The APB payload registers double as the command capture, so
            // they stay constant for the whole transfer and keep their last
            // value afterwards.
            r_apb_write <= cmd_write;
            r_apb_addr  <= cmd_addr;
            r_apb_wdata <= cmd_wdata;
            r_wait_cnt  <= 16'h0;
          end
        end

        ST_SETUP: begin
          r_state  <= ST_ACCESS;
          r_apb_en <= 1'b1;
        end

        ST_ACCESS: begin
          if (apb_ready) begin
            r_state     <= ST_RESP;
            r_apb_sel   <= 1'b0;
            r_apb_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_apb_write ? 32'h0 : apb_rdata;
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= ST_RESP;
            r_apb_sel   <= 1'b0;
            r_apb_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ERR_DATA;
            r_rsp_err   <= 1'b1;
          end else if (r_wait_cnt != 16'hFFFF) begin
            // Saturate so an unlimited wait (TIMEOUT = 0) never wraps.
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        ST_RESP: begin
          if (w_rsp_fire) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_apb_sel   <= 1'b0;
          r_apb_en    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign apb_sel   = r_apb_sel;
  assign apb_en    = r_apb_en;
  assign apb_write = r_apb_write;
  assign apb_addr  = r_apb_addr;
  assign apb_wdata = r_apb_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_i2c_apb_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_apb_master
//   Self-checking bench for i2c_apb_master (TIMEOUT = 4). A table of
//   transfers is replayed; expected responses are queued at command
//   acceptance and popped at the response handshake. A hand-written
//   sequence covers reset in the middle of an ACCESS wait state.
// ---------------------------------------------------------------------------
module tb_i2c_apb_master;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        apb_sel;
  logic        apb_en;
  logic        apb_write;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  logic        busy;

  i2c_apb_master #(.TIMEOUT(16'd4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .apb_ready (apb_ready),
    .apb_rdata (apb_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;      // slave read data presented during ACCESS
    int          waits;      // ACCESS cycles with apb_ready low before ready
    int          bp;         // cycles rsp_ready is held low
    int          exp_acc;    // expected number of ACCESS cycles
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam int NVEC = 8;
  vec_t  vecs [NVEC];
  resp_t sb [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    acc;
    int    guard;
    resp_t exp;
    @(negedge clk);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    apb_rdata = v.rdata;
    apb_ready = 1'b0;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(negedge clk);
    // Cycle N+1: SETUP
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
    check("setup_sel", {31'b0, apb_sel}, 32'd1);
    check("setup_en", {31'b0, apb_en}, 32'd0);
    check("setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("setup_busy", {31'b0, busy}, 32'd1);
    check("setup_addr", apb_addr, v.addr);
    check("setup_wdata", apb_wdata, v.wdata);
    check("setup_write", {31'b0, apb_write}, {31'b0, v.write});
    @(negedge clk);
    // Cycle N+2 onward: ACCESS
    acc   = 0;
    guard = 0;
    while (apb_en === 1'b1 && guard < 40) begin
      acc++;
      guard++;
      check("access_sel", {31'b0, apb_sel}, 32'd1);
      check("access_addr", apb_addr, v.addr);
      check("access_wdata", apb_wdata, v.wdata);
      check("access_write", {31'b0, apb_write}, {31'b0, v.write});
      apb_ready = (acc >= v.waits + 1);
      @(negedge clk);
    end
    apb_ready = 1'b0;
    check("access_cycles", acc, v.exp_acc);
    check("resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("resp_sel", {31'b0, apb_sel}, 32'd0);
    check("resp_en", {31'b0, apb_en}, 32'd0);
    check("resp_addr_hold", apb_addr, v.addr);
    // Backpressure, with a competing command that must not be taken.
    for (int k = 0; k < v.bp; k++) begin
      cmd_valid = 1'b1;
      cmd_write = ~v.write;
      cmd_addr  = 32'hFFFF_0000;
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_sel", {31'b0, apb_sel}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got response with no expected entry");
    end else begin
      exp = sb.pop_front();
      check("rsp_rdata", rsp_rdata, exp.rdata);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, exp.err});
    end
    $display("txn %0d: %s addr=%h acc=%0d rdata=%h err=%b", idx,
             v.write ? "WR" : "RD", v.addr, acc, rsp_rdata, rsp_err);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_sel", {31'b0, apb_sel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          write addr          wdata          rdata          waits bp acc exp_rdata     err
    vecs[0] = '{1'b1, 32'h0000_0108, 32'h0000_005A, 32'h1111_1111, 0,  0, 1, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_00C3, 0,  0, 1, 32'h0000_00C3, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0200, 32'hA5A5_0001, 32'h2222_2222, 3,  0, 4, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 32'h1234_5678, 3,  0, 4, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_CAFE, 10, 0, 4, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0500, 32'h0F0F_0F0F, 32'h3333_3333, 10, 1, 4, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0BAD_F00D, 1,  5, 2, 32'h0BAD_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0108, 32'h0000_0000, 32'h0000_0077, 2,  2, 3, 32'h0000_0077, 1'b0};

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    apb_ready = 1'b0;
    apb_rdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_sel", {31'b0, apb_sel}, 32'd0);
    check("rst_en", {31'b0, apb_en}, 32'd0);
    check("rst_addr", apb_addr, 32'd0);
    check("rst_wdata", apb_wdata, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset while ACCESS is waiting on the slave: the transfer is dropped
    // and the APB strobes fall without waiting for a clock edge.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0600;
    apb_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_en_before_rst", {31'b0, apb_en}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_sel", {31'b0, apb_sel}, 32'd0);
    check("async_rst_en", {31'b0, apb_en}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("after_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("after_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("after_rst_sel", {31'b0, apb_sel}, 32'd0);
    end
    $display("txn reset: mid-ACCESS reset, rsp_valid=%b cmd_ready=%b", rsp_valid, cmd_ready);

    // Normal operation resumes after the abandoned transfer.
    run_vec(vecs[1], NVEC);

    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_apb_master.md
I2C_APB_MASTER -- requirements
Module: i2c_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd255, the maximum number of ACCESS cycles before abort (0 = never abort).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  target address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_rdata  output  32  read data, or 32'hdeadbeef on error.
REQ-012 SHALL have port rsp_err  output  1  1 = transfer timed out.
REQ-013 SHALL have port apb_sel  output  1  APB select.
REQ-014 SHALL have port apb_en  output  1  APB enable (ACCESS phase).
REQ-015 SHALL have port apb_write  output  1  APB direction.
REQ-016 SHALL have port apb_addr  output  32  APB address.
REQ-017 SHALL have port apb_wdata  output  32  APB write data.
REQ-018 SHALL have port apb_ready  input  1  slave completion.
REQ-019 SHALL have port apb_rdata  input  32  slave read data.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement the states IDLE, SETUP, ACCESS and RESP, encoded in a registered state variable.
REQ-022 SHALL drive cmd_ready high only in IDLE; on cmd_valid&cmd_ready, SHALL register cmd_write, cmd_addr and cmd_wdata and go to SETUP.
REQ-023 SHALL, in SETUP, drive apb_sel=1 and apb_en=0 for exactly one cycle, then go to ACCESS.
REQ-024 SHALL, in ACCESS, drive apb_sel=1 and apb_en=1 and sample apb_ready every cycle.
REQ-025 SHALL hold apb_addr, apb_wdata and apb_write constant from SETUP through the last ACCESS cycle; in IDLE and RESP they SHALL retain their last values.
REQ-026 SHALL, on apb_ready=1 in ACCESS, capture apb_rdata into rsp_rdata for reads (32'h0 for writes), set rsp_err=0 and go to RESP.
REQ-027 SHALL count ACCESS cycles with apb_ready=0 in a 16-bit counter that is cleared on entry to SETUP.
REQ-028 SHALL, when TIMEOUT!=0 and the counter equals TIMEOUT-1 with apb_ready=0, set rsp_err=1 and rsp_rdata=32'hdeadbeef and go to RESP, so that ACCESS lasts at most TIMEOUT cycles.
REQ-029 SHALL give apb_ready priority when it is high in the same cycle as the timeout condition (normal completion, rsp_err=0).
REQ-030 SHALL drive apb_sel=0 and apb_en=0 in IDLE and RESP.
REQ-031 SHALL hold rsp_valid=1 in RESP with rsp_rdata and rsp_err stable until rsp_valid&rsp_ready, then go to IDLE.
REQ-032 SHALL give zero-wait-state latency as follows: command accepted in cycle N, SETUP in N+1, ACCESS in N+2, rsp_valid=1 in N+3.
REQ-033 SHALL accept no new command until the previous response has been consumed (one transfer outstanding).

Reset
REQ-034 SHALL, while rstn=0, force state IDLE, all APB outputs to 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0 and busy=0; cmd_ready SHALL be 1 from the first cycle after reset release.
REQ-035 SHALL abandon any in-flight transfer on reset, emit no response for it, and deassert apb_sel and apb_en immediately (asynchronously).

Verification
REQ-036 Write: cmd addr=32'h108, wdata=32'h5A, apb_ready=1 -> one SETUP cycle and one ACCESS cycle with apb_write=1 and apb_wdata=32'h5A; rsp_valid at N+3 with rsp_err=0.
REQ-037 Read: cmd addr=32'h104, apb_rdata=32'h000000C3 during ACCESS -> rsp_rdata=32'hC3, rsp_err=0.
REQ-038 Wait states: apb_ready low for 3 ACCESS cycles, then high -> ACCESS lasts 4 cycles with addr, wdata and write stable throughout; rsp_err=0.
REQ-039 Timeout: TIMEOUT=4, apb_ready held 0 -> exactly 4 ACCESS cycles; rsp_err=1, rsp_rdata=32'hdeadbeef; with apb_ready=1 in the 4th cycle -> rsp_err=0.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, a second cmd_valid is not accepted until the response handshake completes.
REQ-041 Reset mid-ACCESS: rstn pulsed low during a wait state -> apb_sel and apb_en go to 0 immediately, no rsp_valid, cmd_ready=1 after release.
